seh_clkgate_ctrl: RTL and testbench



---
 rtl/seh_cg_pkg.sv | 22 ++
 rtl/seh_clkgate_ctrl_if.sv | 27 ++
 rtl/seh_cg_en_retime.sv | 24 ++
 rtl/seh_clkgate_ctrl.sv | 117 +++++++++++
 tb/tb_seh_clkgate_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/seh_cg_pkg.sv
// Shared constants for the clock-gate enable controller: state encoding,
// default timing parameters and counter-width derivation.
package seh_cg_pkg;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_WAKE  = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int WAKE_CYCLES_DEF = 2;
    localparam int IDLE_CYCLES_DEF = 16;
    localparam int STAT_W_DEF      = 16;

    // A down-counter loaded with CYCLES-1 never needs more than clog2(CYCLES) bits.
    function automatic int cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    localparam int WCNT_W = cnt_w(WAKE_CYCLES_DEF);
    localparam int ICNT_W = cnt_w(IDLE_CYCLES_DEF);

endpackage

// File: rtl/seh_clkgate_ctrl_if.sv
// Client-side signal bundle of the clock-gate controller; the controller
// takes the slave view, the gated-domain client the master view.
interface seh_clkgate_ctrl_if #(
    parameter int STAT_W = 16
) ();

    logic              REQ;
    logic              BUSY;
    logic              FORCE_ON;
    logic              TEST_EN;
    logic              STAT_CLR;
    logic              GEN;
    logic              ACK;
    logic [1:0]        STATE;
    logic [STAT_W-1:0] GATED_CNT;

    modport master (
        output REQ, BUSY, FORCE_ON, TEST_EN, STAT_CLR,
        input  GEN, ACK, STATE, GATED_CNT
    );

    modport slave (
        input  REQ, BUSY, FORCE_ON, TEST_EN, STAT_CLR,
        output GEN, ACK, STATE, GATED_CNT
    );

endinterface

// File: rtl/seh_cg_en_retime.sv
// Falling-edge retime of the gate enable plus the scan override; the only
// negedge element of the controller lives here.
module seh_cg_en_retime (
    input  logic CK,
    input  logic RN,
    input  logic i_en,
    input  logic i_test_en,
    output logic o_gen
);

    logic r_gen_q;

    // Capture while CK falls so the AND2 enable only moves during CK low
    always_ff @(negedge CK or negedge RN) begin
        if (!RN) begin
            r_gen_q <= 1'b0;
        end else begin
            r_gen_q <= i_en;
        end
    end

    assign o_gen = r_gen_q | i_test_en;

endmodule

// File: rtl/seh_clkgate_ctrl.sv
// Clock-gate enable controller: wake settling, idle-timeout drain, scan
// override and a saturating count of cycles spent gated off.
module seh_clkgate_ctrl
    import seh_cg_pkg::*;
#(
    parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int STAT_W      = STAT_W_DEF
) (
    input  logic             CK,
    input  logic             RN,
    seh_clkgate_ctrl_if.slave cg_bus
);

    localparam int WC_W = cnt_w(WAKE_CYCLES);
    localparam int IC_W = cnt_w(IDLE_CYCLES);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WC_W-1:0]   r_wcnt;
    logic [WC_W-1:0]   w_wcnt_nxt;
    logic [IC_W-1:0]   r_icnt;
    logic [IC_W-1:0]   w_icnt_nxt;
    logic              r_ack;
    logic              w_ack_nxt;
    logic [STAT_W-1:0] r_gated_cnt;
    logic              w_act;

    assign w_act = cg_bus.REQ | cg_bus.BUSY | cg_bus.FORCE_ON;

    // Next-state and counter-load decisions of the gating sequence
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_icnt_nxt  = r_icnt;
        case (r_state)
            ST_OFF: begin
                if (w_act) begin
                    w_state_nxt = ST_WAKE;
                    w_wcnt_nxt  = WC_W'(WAKE_CYCLES - 1);
                end else begin
                    w_state_nxt = ST_OFF;
                end
            end
            ST_WAKE: begin
                if (r_wcnt == {WC_W{1'b0}}) begin
                    w_state_nxt = ST_ON;
                end else begin
                    w_wcnt_nxt = r_wcnt - WC_W'(1);
                end
            end
            ST_ON: begin
                if (!w_act) begin
                    w_state_nxt = ST_DRAIN;
                    w_icnt_nxt  = IC_W'(IDLE_CYCLES - 1);
                end else begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_DRAIN: begin
                // Fresh activity beats the timeout, even on the terminal cycle
                if (w_act) begin
                    w_state_nxt = ST_ON;
                end else if (r_icnt == {IC_W{1'b0}}) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_icnt_nxt = r_icnt - IC_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
        w_ack_nxt = (w_state_nxt == ST_ON) | (w_state_nxt == ST_DRAIN);
    end

    // FSM state, settle/idle counters and the ACK flop
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= ST_OFF;
            r_wcnt  <= {WC_W{1'b0}};
            r_icnt  <= {IC_W{1'b0}};
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_icnt  <= w_icnt_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    // Saturating count of cycles spent gated off; clear wins over count
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_gated_cnt <= {STAT_W{1'b0}};
        end else if (cg_bus.STAT_CLR) begin
            r_gated_cnt <= {STAT_W{1'b0}};
        end else if ((r_state == ST_OFF) && (r_gated_cnt != {STAT_W{1'b1}})) begin
            r_gated_cnt <= r_gated_cnt + STAT_W'(1);
        end else begin
            r_gated_cnt <= r_gated_cnt;
        end
    end

    seh_cg_en_retime u_retime (
        .CK        (CK),
        .RN        (RN),
        .i_en      (r_state != ST_OFF),
        .i_test_en (cg_bus.TEST_EN),
        .o_gen     (cg_bus.GEN)
    );

    assign cg_bus.ACK       = r_ack;
    assign cg_bus.STATE     = r_state;
    assign cg_bus.GATED_CNT = r_gated_cnt;

endmodule

// File: tb/tb_seh_clkgate_ctrl.sv
// Scoreboard bench for seh_clkgate_ctrl: a 16-bit-counter instance and a
// 4-bit-counter instance share stimulus; expectations are queued by cycle.
module tb_seh_clkgate_ctrl;

    logic CK = 1'b0;
    logic RN = 1'b0;
    logic req_s = 1'b0, busy_s = 1'b0, force_s = 1'b0, test_s = 1'b0, clr_s = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct packed {
        int           cyc;
        logic [127:0] name;
        logic [1:0]   st;
        logic         ack;
        logic         gen;
        int           cnt;
        int           cnt4;
    } exp_t;

    exp_t sb_q[$];

    seh_clkgate_ctrl_if #(.STAT_W(16)) bus16 ();
    seh_clkgate_ctrl_if #(.STAT_W(4))  bus4 ();

    assign bus16.REQ = req_s;   assign bus16.BUSY = busy_s;  assign bus16.FORCE_ON = force_s;
    assign bus16.TEST_EN = test_s; assign bus16.STAT_CLR = clr_s;
    assign bus4.REQ = req_s;    assign bus4.BUSY = busy_s;   assign bus4.FORCE_ON = force_s;
    assign bus4.TEST_EN = test_s;  assign bus4.STAT_CLR = clr_s;

    seh_clkgate_ctrl #(.WAKE_CYCLES(2), .IDLE_CYCLES(16), .STAT_W(16)) dut (
        .CK(CK), .RN(RN), .cg_bus(bus16.slave)
    );
    seh_clkgate_ctrl #(.WAKE_CYCLES(2), .IDLE_CYCLES(16), .STAT_W(4)) dut4 (
        .CK(CK), .RN(RN), .cg_bus(bus4.slave)
    );

    always #5 CK = ~CK;

    always @(posedge CK) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge CK);
        #2;
    endtask

    // Queue an expectation for the sample taken off cycles from now (cnt4 < 0: skip).
    task automatic expect_at(input int off, input logic [127:0] nm, input logic [1:0] st,
                             input logic ack, input logic gen, input int cnt, input int cnt4);
        exp_t e;
        e.cyc = cyc + off; e.name = nm; e.st = st; e.ack = ack; e.gen = gen;
        e.cnt = cnt; e.cnt4 = cnt4;
        sb_q.push_back(e);
    endtask

    task automatic check_one(input exp_t e);
        logic ok;
        ok = (e.cyc == cyc) && (bus16.STATE === e.st) && (bus4.STATE === e.st)
             && (bus16.ACK === e.ack) && (bus16.GEN === e.gen)
             && (bus16.GATED_CNT === e.cnt[15:0])
             && ((e.cnt4 < 0) || (bus4.GATED_CNT === e.cnt4[3:0]));
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %0s @cyc %0d (due %0d): got st=%0d/%0d ack=%0b gen=%0b cnt=%0d cnt4=%0d, want st=%0d ack=%0b gen=%0b cnt=%0d cnt4=%0d",
                     e.name, cyc, e.cyc, bus16.STATE, bus4.STATE, bus16.ACK, bus16.GEN,
                     bus16.GATED_CNT, bus4.GATED_CNT, e.st, e.ack, e.gen, e.cnt, e.cnt4);
        end
    endtask

    // Monitor: sample mid-high phase, retire every expectation due this cycle
    initial begin
        forever begin
            @(posedge CK);
            #1;
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc <= cyc) begin
                    check_one(sb_q[i]);
                    sb_q.delete(i);
                end
            end
        end
    end

    initial begin
        int base;
        test_s = 1'b1;
        step(1);
        expect_at(1, "rst_scan", 2'd0, 1'b0, 1'b1, 0, 0);
        step(1);
        test_s = 1'b0;
        expect_at(1, "rst_idle", 2'd0, 1'b0, 1'b0, 0, 0);
        step(1);

        // 1: single-cycle REQ pulse, full wake/drain/off sequence
        RN = 1'b1;
        step(9);
        req_s = 1'b1;
        expect_at(1,  "t1_wake0",   2'd1, 1'b0, 1'b0, 10, 10);
        expect_at(2,  "t1_wake1",   2'd1, 1'b0, 1'b1, 10, 10);
        expect_at(3,  "t1_on",      2'd2, 1'b1, 1'b1, 10, 10);
        expect_at(4,  "t1_drain",   2'd3, 1'b1, 1'b1, 10, 10);
        expect_at(19, "t1_drain_end", 2'd3, 1'b1, 1'b1, 10, 10);
        expect_at(20, "t1_off",     2'd0, 1'b0, 1'b1, 10, 10);
        expect_at(21, "t1_gen_low", 2'd0, 1'b0, 1'b0, 11, 11);
        step(1);
        req_s = 1'b0;
        step(21);

        // 2: BUSY arrives exactly on the terminal idle cycle
        req_s = 1'b1;
        expect_at(3,  "t2_on",      2'd2, 1'b1, 1'b1, 13, 13);
        expect_at(4,  "t2_drain",   2'd3, 1'b1, 1'b1, 13, 13);
        expect_at(19, "t2_last_idle", 2'd3, 1'b1, 1'b1, 13, 13);
        expect_at(20, "t2_busy_save", 2'd2, 1'b1, 1'b1, 13, 13);
        expect_at(21, "t2_drain2",  2'd3, 1'b1, 1'b1, 13, 13);
        expect_at(36, "t2_drain2_end", 2'd3, 1'b1, 1'b1, 13, 13);
        expect_at(37, "t2_off",     2'd0, 1'b0, 1'b1, 13, 13);
        step(1);
        req_s = 1'b0;
        step(18);
        busy_s = 1'b1;
        step(1);
        busy_s = 1'b0;
        step(17);

        // 3: reset mid-WAKE, then a clean restart
        req_s = 1'b1;
        step(1);
        RN = 1'b0;
        req_s = 1'b0;
        expect_at(1, "t3_rst", 2'd0, 1'b0, 1'b0, 0, 0);
        step(1);
        RN = 1'b1;
        step(2);
        req_s = 1'b1;
        expect_at(1, "t3_rewake", 2'd1, 1'b0, 1'b0, 3, 3);
        expect_at(2, "t3_wake_hold", 2'd1, 1'b0, 1'b1, 3, 3);
        expect_at(3, "t3_reon",   2'd2, 1'b1, 1'b1, 3, 3);
        step(1);
        req_s = 1'b0;
        step(20);

        // 4 and 5: scan override while gated off, counter saturation and clear
        clr_s = 1'b1;
        expect_at(1, "t4_clr", 2'd0, 1'b0, 1'b0, 0, 0);
        step(1);
        clr_s = 1'b0;
        test_s = 1'b1;
        expect_at(1,  "t4_scan_on", 2'd0, 1'b0, 1'b1, 1, 1);
        expect_at(15, "t5_cnt15",   2'd0, 1'b0, 1'b1, 15, 15);
        expect_at(20, "t5_sat",     2'd0, 1'b0, 1'b1, 20, 15);
        expect_at(50, "t4_cnt50",   2'd0, 1'b0, 1'b1, 50, 15);
        step(50);
        clr_s = 1'b1;
        test_s = 1'b0;
        expect_at(1, "t5_clr", 2'd0, 1'b0, 1'b0, 0, 0);
        step(1);
        clr_s = 1'b0;
        expect_at(1, "t5_resume1", 2'd0, 1'b0, 1'b0, 1, 1);
        expect_at(2, "t5_resume2", 2'd0, 1'b0, 1'b0, 2, 2);
        step(3);

        // 6: FORCE_ON held from reset pins the FSM in ON
        RN = 1'b0;
        force_s = 1'b1;
        expect_at(1, "t6_rst", 2'd0, 1'b0, 1'b0, 0, 0);
        step(1);
        RN = 1'b1;
        expect_at(1,   "t6_wake",     2'd1, 1'b0, 1'b0, 1, 1);
        expect_at(3,   "t6_on",       2'd2, 1'b1, 1'b1, 1, 1);
        expect_at(50,  "t6_hold",     2'd2, 1'b1, 1'b1, 1, 1);
        expect_at(100, "t6_hold_end", 2'd2, 1'b1, 1'b1, 1, 1);
        step(100);
        force_s = 1'b0;

        base = 0;
        while ((base < 200) && (sb_q.size() != 0)) begin
            @(posedge CK);
            base++;
        end
        #5;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations never retired, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
